// File: rtl/matrix_pkg.sv
// Shared constants, types and helpers for the matrix row RAM read path.
package matrix_pkg;

   localparam int DATA_W = 256;            // row width in bits
   localparam int DEPTH  = 16;             // rows in the target RAM
   localparam int ADDR_W = 5;              // RAM address width (MSB unused at DEPTH=16)
   localparam int LEN_W  = 5;              // command length width, legal 0..DEPTH
   localparam int PTR_W  = $clog2(DEPTH);  // row pointer width, wraps modulo DEPTH

   typedef logic [DATA_W-1:0] row_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

   // Lengths beyond the RAM depth read every row exactly once.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
   endfunction

endpackage

// File: rtl/matrix_row_fifo2.sv
// Two-entry register FIFO that absorbs the RAM read latency in front of the
// row stream. A push and a pop in the same cycle are accepted even when full.
module matrix_row_fifo2
   import matrix_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  row_t       i_din,
   input  logic       i_pop,
   output row_t       o_dout,
   output logic [1:0] o_count,
   output logic       o_full,
   output logic       o_empty
);

   row_t       r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_do_pop;
   logic       w_do_push;

   assign o_full    = (r_count == 2'd2);
   assign o_empty   = (r_count == 2'd0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage: the entry under the write pointer loads on an accepted push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/matrix_row_reader.sv
// Read-side initiator for one port of the matrix row RAM: takes (base, len),
// issues sequential reads and streams the rows out over valid/ready.
// Optional build macro MATRIX_ROW_LAST_EN adds the m_last output.
module matrix_row_reader
   import matrix_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_base,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wen,
   output logic [DATA_W-1:0] ram_d,
   input  logic [DATA_W-1:0] ram_q,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              busy,
   output logic              done
`ifdef MATRIX_ROW_LAST_EN
   ,
   output logic              m_last
`endif
);

   rd_state_e         r_state;
   rd_state_e         w_state_next;
   logic [PTR_W-1:0]  r_addr_ptr;
   logic [LEN_W-1:0]  r_rem;
   logic [ADDR_W-1:0] r_addr_hold;
   logic              r_inflight;
   logic              r_done;
   logic              w_issue;
   logic              w_done_next;
   logic              w_start;
   logic              w_pop;
   logic              w_credit_ok;
   logic              w_full;
   logic              w_empty;
   logic [1:0]        w_cnt;
   row_t              w_dout;

   assign cmd_ready = (r_state == IDLE);
   assign busy      = (r_state == RUN) || (r_state == DRAIN);
   assign done      = r_done;
   assign ram_wen   = 1'b0;
   assign ram_d     = '0;
   assign m_valid   = !w_empty;
   assign m_data    = w_dout;
   assign w_pop     = m_valid && m_ready;
   assign w_start   = cmd_ready && cmd_valid && (cmd_len != '0);

   // A row still travelling through the RAM counts against the two FIFO
   // slots; a pop in the same cycle frees one.
   assign w_credit_ok = w_pop || !(w_full || ((w_cnt == 2'd1) && r_inflight));

   // The address moves only on an issue cycle and otherwise keeps the last one.
   assign ram_addr = w_issue ? ADDR_W'(r_addr_ptr) : r_addr_hold;

   matrix_row_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_inflight),
      .i_din   (ram_q),
      .i_pop   (w_pop),
      .o_dout  (w_dout),
      .o_count (w_cnt),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   // Next state, read issue and completion decode.
   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_done_next  = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_len == '0) w_done_next  = 1'b1;
               else               w_state_next = RUN;
            end
         end
         RUN: begin
            if ((r_rem != '0) && w_credit_ok) begin
               w_issue = 1'b1;
               if (r_rem == LEN_W'(1)) w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!r_inflight && ((w_cnt == 2'd0) || ((w_cnt == 2'd1) && w_pop))) begin
               w_state_next = IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Read pointer, remaining count, in-flight flag and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr_ptr  <= '0;
         r_rem       <= '0;
         r_addr_hold <= '0;
         r_inflight  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         r_done     <= w_done_next;
         if (w_start) begin
            r_addr_ptr <= PTR_W'(cmd_base);
            r_rem      <= clamp_len(cmd_len);
         end else if (w_issue) begin
            r_addr_ptr  <= r_addr_ptr + PTR_W'(1);
            r_rem       <= r_rem - LEN_W'(1);
            r_addr_hold <= ram_addr;
         end
      end
   end

`ifdef MATRIX_ROW_LAST_EN
   logic [LEN_W-1:0] r_out_rem;

   // Rows still to be handed downstream for the current command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         r_out_rem <= '0;
      else if (w_start)                   r_out_rem <= clamp_len(cmd_len);
      else if (w_pop && r_out_rem != '0)  r_out_rem <= r_out_rem - LEN_W'(1);
   end

   assign m_last = m_valid && (r_out_rem == LEN_W'(1));
`endif

endmodule

// File: tb/tb_matrix_row_reader.sv
// Self-checking bench for matrix_row_reader: RAM model, randomized
// downstream backpressure and a queue-based model of the expected stream.
module tb_matrix_row_reader;
   import matrix_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_base = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_wen;
   logic [DATA_W-1:0] ram_d;
   row_t              ram_q;
   logic              m_valid;
   logic              m_ready = 1'b1;
   logic [DATA_W-1:0] m_data;
   logic              busy;
   logic              done;
`ifdef MATRIX_ROW_LAST_EN
   logic              m_last;
`endif

   row_t mem [DEPTH];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int exp_q[$];
   int addr_log[$];
   bit active = 0;
   bit done_due = 0;
   bit waiting_first = 0;
   bit prev_stall = 0;
   bit consec = 0;
   bit rand_mode = 0;
   int acc_cycle = 0;
   int last_pop_cyc = -1;
   int stall_cnt = 0;
   int rows_seen = 0;
   int log_n = 0;
   int last_addr_exp = 0;

   matrix_row_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_base  (cmd_base),
      .cmd_len   (cmd_len),
      .ram_addr  (ram_addr),
      .ram_wen   (ram_wen),
      .ram_d     (ram_d),
      .ram_q     (ram_q),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .busy      (busy),
      .done      (done)
`ifdef MATRIX_ROW_LAST_EN
      ,
      .m_last    (m_last)
`endif
   );

   always #5 clk = ~clk;

   // RAM model: one-cycle registered read.
   always @(posedge clk) ram_q <= mem[ram_addr[PTR_W-1:0]];

   function automatic row_t row_of(input int a);
      return {8{a[31:0]}};
   endfunction

   task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the model, sampled at the falling edge.
   task automatic monitor();
      bit ev;
      bit was_active;
      int a;
      int n;
      cyc++;
      ev = 0;
      was_active = active;
      check_eq("done", DATA_W'(done), DATA_W'(done_due));
      check_eq("busy", DATA_W'(busy), DATA_W'(active));
      check_eq("cmd_ready", DATA_W'(cmd_ready), DATA_W'(!active));
      if (!active) check_eq("ram_addr_idle", DATA_W'(ram_addr), DATA_W'(last_addr_exp));
      if (prev_stall && rst_n) check_eq("hold_valid", DATA_W'(m_valid), DATA_W'(1));
      if (exp_q.size() == 0) begin
         check_eq("no_extra_row", DATA_W'(m_valid), DATA_W'(0));
      end else if (m_valid) begin
         if (waiting_first) begin
            check_eq("first_latency", DATA_W'(cyc - acc_cycle), DATA_W'(3));
            waiting_first = 0;
         end
         check_eq("row_data", m_data, row_of(exp_q[0]));
`ifdef MATRIX_ROW_LAST_EN
         check_eq("m_last", DATA_W'(m_last), DATA_W'(exp_q.size() == 1));
`endif
         if (m_ready) begin
            a = exp_q.pop_front();
            if (consec && last_pop_cyc >= 0)
               check_eq("back_to_back", DATA_W'(cyc - last_pop_cyc), DATA_W'(1));
            last_pop_cyc = cyc;
            rows_seen++;
            $display("row addr=%0d data=%0h cycle=%0d", a, m_data[31:0], cyc);
            if (exp_q.size() == 0) begin
               ev = 1;
               active = 0;
            end
         end
      end
      if (cmd_valid && !was_active && rst_n) begin
         n = (int'(cmd_len) > DEPTH) ? DEPTH : int'(cmd_len);
         $display("cmd base=%0d len=%0d rows=%0d cycle=%0d", cmd_base, cmd_len, n, cyc);
         if (n == 0) begin
            ev = 1;
         end else begin
            for (int i = 0; i < n; i++) exp_q.push_back((int'(cmd_base) + i) % DEPTH);
            active = 1;
            waiting_first = 1;
            acc_cycle = cyc;
            last_pop_cyc = -1;
            last_addr_exp = (int'(cmd_base) + n - 1) % DEPTH;
         end
      end
      done_due = ev;
      prev_stall = m_valid && !m_ready;
      if (log_n > 0) begin
         addr_log.push_back(int'(ram_addr));
         log_n--;
      end
   endtask

   // One clock: check at the falling edge, then drive m_ready after the rise.
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
         m_ready = 1'b0;
         stall_cnt--;
      end else if (rand_mode) begin
         m_ready = ($urandom_range(0, 99) < 30);
      end else begin
         m_ready = 1'b1;
      end
   endtask

   task automatic send_cmd(input int base, input int len);
      cmd_base  = ADDR_W'(base);
      cmd_len   = LEN_W'(len);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      bit idle;
      n = 0;
      while ((active || done_due || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      idle = !(active || done_due || exp_q.size() != 0);
      check_eq("finish_in_budget", DATA_W'(idle), DATA_W'(1));
   endtask

   initial begin
      int start;
      int n;
      int exp_addr[4];
      bit stalled;
      exp_addr = '{14, 15, 0, 1};
      for (int i = 0; i < DEPTH; i++) mem[i] = row_of(i);

      // Reset state
      #12;
      check_eq("rst_cmd_ready", DATA_W'(cmd_ready), DATA_W'(1));
      check_eq("rst_m_valid", DATA_W'(m_valid), DATA_W'(0));
      check_eq("rst_m_data", m_data, '0);
      check_eq("rst_ram_addr", DATA_W'(ram_addr), DATA_W'(0));
      check_eq("rst_busy", DATA_W'(busy), DATA_W'(0));
      check_eq("rst_done", DATA_W'(done), DATA_W'(0));
      check_eq("rst_ram_wen", DATA_W'(ram_wen), DATA_W'(0));
      check_eq("rst_ram_d", ram_d, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // T1 basic full sweep
      consec = 1;
      send_cmd(0, 16);
      wait_idle(60);

      // T2 wrap and address sequence
      addr_log.delete();
      send_cmd(14, 4);
      log_n = 4;
      wait_idle(40);
      check_eq("addr_log_len", DATA_W'(addr_log.size()), DATA_W'(4));
      for (int i = 0; i < 4 && i < addr_log.size(); i++)
         check_eq("ram_addr_seq", DATA_W'(addr_log[i]), DATA_W'(exp_addr[i]));

      // T3 random backpressure with a mid-stream stall
      consec = 0;
      rand_mode = 1;
      start = rows_seen;
      stalled = 0;
      send_cmd(5, 8);
      n = 0;
      while ((active || done_due || exp_q.size() != 0) && n < 400) begin
         tick();
         n++;
         if (!stalled && rows_seen == start + 4) begin
            stall_cnt = 5;
            stalled = 1;
         end
      end
      check_eq("t3_finish", DATA_W'(active || exp_q.size() != 0), DATA_W'(0));
      check_eq("t3_rows", DATA_W'(rows_seen - start), DATA_W'(8));
      rand_mode = 0;
      tick();

      // T4 zero length, then clamped length
      send_cmd(9, 0);
      wait_idle(10);
      for (int i = 0; i < 4; i++) tick();
      consec = 1;
      start = rows_seen;
      send_cmd(3, 20);
      wait_idle(60);
      check_eq("t4_clamp_rows", DATA_W'(rows_seen - start), DATA_W'(16));

      // T5 reset in the middle of a command
      start = rows_seen;
      send_cmd(6, 10);
      n = 0;
      while (rows_seen < start + 3 && n < 30) begin
         tick();
         n++;
      end
      rst_n = 1'b0;
      #1;
      check_eq("t5_m_valid", DATA_W'(m_valid), DATA_W'(0));
      check_eq("t5_busy", DATA_W'(busy), DATA_W'(0));
      check_eq("t5_cmd_ready", DATA_W'(cmd_ready), DATA_W'(1));
      check_eq("t5_done", DATA_W'(done), DATA_W'(0));
      exp_q.delete();
      active = 0;
      done_due = 0;
      waiting_first = 0;
      prev_stall = 0;
      last_pop_cyc = -1;
      last_addr_exp = 0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      start = rows_seen;
      send_cmd(0, 2);
      wait_idle(20);
      check_eq("t5_rows_after", DATA_W'(rows_seen - start), DATA_W'(2));

      // T6 last-row marker held across a stall
      consec = 0;
      start = rows_seen;
      send_cmd(2, 3);
      tick();
      tick();
      tick();
      stall_cnt = 2;
      wait_idle(30);
      check_eq("t6_rows", DATA_W'(rows_seen - start), DATA_W'(3));
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached with errors=%0d checks=%0d", errors, checks);
      $fatal(1, "time limit");
   end

endmodule
